// File: rtl/ms_cmd_que.sv
// ms_cmd_que: instruction prefetch queue in front of the command decoder.
// Fetches 32-bit code words, stores them as halfwords in a circular buffer,
// exposes the next three halfwords at the current IP and pops retired commands.
module ms_cmd_que #(
  parameter int unsigned DEPTH_HW = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AIpLoad,
  input  logic [22:0]       AIpNew,
  output logic              ACodeRdReq,
  output logic [21:0]       ACodeAddr,
  input  logic              ACodeRdAck,
  input  logic              ACodeDataVld,
  input  logic [31:0]       ACodeMiso,
  output logic [47:0]       AQueTop,
  output logic [CNT_W-1:0]  AQueCnt,
  output logic [22:0]       AIpThis,
  input  logic [1:0]        ACmdLen,
  output logic              ACmdLenValid,
  input  logic              ACmdPop
);

  localparam int unsigned PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_HW);

  logic [15:0]      mem_q [DEPTH_HW];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [22:0]      ip_this_q;
  logic [21:0]      fetch_addr_q;
  logic             skip_lo_q;
  logic             pend_q;
  logic             discard_q;

  logic             data_take;
  logic             data_store;
  logic [1:0]       wr_n;
  logic [1:0]       pop_n;
  logic [CNT_W-1:0] free_hw;

  assign data_take  = ACodeDataVld && pend_q;
  assign data_store = data_take && !discard_q && !AIpLoad;
  assign free_hw    = DEPTH_C - cnt_q;

  // Reset gates the request so every output reads zero while reset is held.
  assign ACodeRdReq   = !AResetH && !pend_q && (free_hw >= CNT_W'(2)) && !AIpLoad;
  assign ACodeAddr    = fetch_addr_q;
  assign AQueCnt      = cnt_q;
  assign AIpThis      = ip_this_q;
  assign ACmdLenValid = (ACmdLen != 2'd0) && (cnt_q >= CNT_W'(ACmdLen));

  // Halfwords written, halfwords popped and the resulting fill count.
  always_comb begin
    wr_n  = 2'd0;
    pop_n = 2'd0;
    if (data_store) wr_n = skip_lo_q ? 2'd1 : 2'd2;
    if (ACmdPop && ACmdLenValid && !AIpLoad) pop_n = ACmdLen;
    cnt_d = cnt_q + CNT_W'(wr_n) - CNT_W'(pop_n);
  end

  // Present up to three halfwords from the head, zero-filled beyond the count.
  always_comb begin
    AQueTop = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (cnt_q > CNT_W'(k)) AQueTop[16*k +: 16] = mem_q[rd_ptr_q + PTR_W'(k)];
    end
  end

  // Halfword storage; an unaligned restart keeps only the upper halfword.
  always_ff @(posedge AClkH) begin
    if (!AResetH && data_store) begin
      if (skip_lo_q) begin
        mem_q[wr_ptr_q] <= ACodeMiso[31:16];
      end else begin
        mem_q[wr_ptr_q]               <= ACodeMiso[15:0];
        mem_q[wr_ptr_q + PTR_W'(1)]   <= ACodeMiso[31:16];
      end
    end
  end

  // Pointers, count, IP and fetch-handshake state; an IP load overrides all else.
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      ip_this_q    <= '0;
      fetch_addr_q <= '0;
      skip_lo_q    <= 1'b0;
      pend_q       <= 1'b0;
      discard_q    <= 1'b0;
    end else if (AIpLoad) begin
      cnt_q        <= '0;
      rd_ptr_q     <= wr_ptr_q;
      ip_this_q    <= AIpNew;
      fetch_addr_q <= AIpNew[22:1];
      skip_lo_q    <= AIpNew[0];
      // Data landing in the load cycle is the outstanding read itself, so
      // nothing is left to discard; otherwise a pending read becomes stale.
      if (data_take) begin
        pend_q    <= 1'b0;
        discard_q <= 1'b0;
      end else begin
        discard_q <= pend_q;
      end
    end else begin
      if (ACodeRdReq && ACodeRdAck) begin
        pend_q       <= 1'b1;
        fetch_addr_q <= fetch_addr_q + 22'd1;
      end
      if (data_take) begin
        pend_q <= 1'b0;
        if (discard_q) discard_q <= 1'b0;
        else if (skip_lo_q) skip_lo_q <= 1'b0;
      end
      wr_ptr_q  <= wr_ptr_q + PTR_W'(wr_n);
      rd_ptr_q  <= rd_ptr_q + PTR_W'(pop_n);
      ip_this_q <= ip_this_q + 23'(pop_n);
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ms_cmd_que.sv
// Directed bench for ms_cmd_que with hand-computed expectations.
module tb_ms_cmd_que;

  logic        AClkH = 1'b0;
  logic        AResetH;
  logic        AIpLoad;
  logic [22:0] AIpNew;
  logic        ACodeRdReq;
  logic [21:0] ACodeAddr;
  logic        ACodeRdAck;
  logic        ACodeDataVld;
  logic [31:0] ACodeMiso;
  logic [47:0] AQueTop;
  logic [3:0]  AQueCnt;
  logic [22:0] AIpThis;
  logic [1:0]  ACmdLen;
  logic        ACmdLenValid;
  logic        ACmdPop;

  int errors = 0;
  int checks = 0;

  ms_cmd_que #(.DEPTH_HW(8), .CNT_W(4)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AIpLoad(AIpLoad), .AIpNew(AIpNew),
    .ACodeRdReq(ACodeRdReq), .ACodeAddr(ACodeAddr), .ACodeRdAck(ACodeRdAck),
    .ACodeDataVld(ACodeDataVld), .ACodeMiso(ACodeMiso), .AQueTop(AQueTop),
    .AQueCnt(AQueCnt), .AIpThis(AIpThis), .ACmdLen(ACmdLen),
    .ACmdLenValid(ACmdLenValid), .ACmdPop(ACmdPop)
  );

  always #5 AClkH = ~AClkH;

  task automatic cyc();
    @(posedge AClkH);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    AResetH = 1'b1; AIpLoad = 1'b0; AIpNew = '0; ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b0; ACodeMiso = '0; ACmdLen = 2'd1; ACmdPop = 1'b0;
    cyc(); cyc();
    chk("rst_req", 48'(ACodeRdReq), 48'd0);
    chk("rst_addr", 48'(ACodeAddr), 48'd0);
    chk("rst_top", AQueTop, 48'd0);
    chk("rst_cnt", 48'(AQueCnt), 48'd0);
    chk("rst_ip", 48'(AIpThis), 48'd0);
    chk("rst_lenvld", 48'(ACmdLenValid), 48'd0);

    // Aligned start at halfword 0x100
    AResetH = 1'b0; AIpLoad = 1'b1; AIpNew = 23'h000100;
    #1 chk("load_blocks_req", 48'(ACodeRdReq), 48'd0);
    cyc(); AIpLoad = 1'b0;
    #1 chk("t1_req", 48'(ACodeRdReq), 48'd1);
    chk("t1_addr0", 48'(ACodeAddr), 48'h80);
    chk("t1_ip", 48'(AIpThis), 48'h100);
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    #1 chk("t1_req_pend", 48'(ACodeRdReq), 48'd0);
    ACodeDataVld = 1'b1; ACodeMiso = 32'hBBBB_AAAA; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t1_cnt2", 48'(AQueCnt), 48'd2);
    chk("t1_top2", AQueTop, 48'h0000_BBBB_AAAA);
    chk("t1_addr1", 48'(ACodeAddr), 48'h81);
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'hDDDD_CCCC; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t1_cnt4", 48'(AQueCnt), 48'd4);
    chk("t1_top4", AQueTop, 48'hCCCC_BBBB_AAAA);

    // Odd-halfword start: only the upper half of the first word is kept
    AIpLoad = 1'b1; AIpNew = 23'h000101; cyc(); AIpLoad = 1'b0;
    #1 chk("t2_cnt0", 48'(AQueCnt), 48'd0);
    chk("t2_top0", AQueTop, 48'd0);
    chk("t2_addr", 48'(ACodeAddr), 48'h80);
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h2222_1111; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t2_cnt1", 48'(AQueCnt), 48'd1);
    chk("t2_top", AQueTop, 48'h0000_0000_2222);
    chk("t2_ip", 48'(AIpThis), 48'h101);

    // Length validity and pop
    AIpLoad = 1'b1; AIpNew = 23'h000200; cyc(); AIpLoad = 1'b0;
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h6666_5555; cyc(); ACodeDataVld = 1'b0;
    ACmdLen = 2'd3;
    #1 chk("t3_len3_cnt2", 48'(ACmdLenValid), 48'd0);
    ACmdPop = 1'b1; cyc(); ACmdPop = 1'b0;
    #1 chk("t3_ignpop_cnt", 48'(AQueCnt), 48'd2);
    chk("t3_ignpop_ip", 48'(AIpThis), 48'h200);
    chk("t3_addr", 48'(ACodeAddr), 48'h101);
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h8888_7777; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t3_len3_cnt4", 48'(ACmdLenValid), 48'd1);
    chk("t3_top", AQueTop, 48'h7777_6666_5555);
    ACmdPop = 1'b1; cyc(); ACmdPop = 1'b0;
    #1 chk("t3_pop_ip", 48'(AIpThis), 48'h203);
    chk("t3_pop_cnt", 48'(AQueCnt), 48'd1);
    chk("t3_pop_top", AQueTop, 48'h0000_0000_8888);
    ACmdLen = 2'd0;
    #1 chk("t3_len0", 48'(ACmdLenValid), 48'd0);

    // Fill to 7, request stops; pop re-enables; write plus pop nets out
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h0B0B_0A0A; cyc(); ACodeDataVld = 1'b0;
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h0D0D_0C0C; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t4_cnt5_req", 48'(ACodeRdReq), 48'd1);
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h0F0F_0E0E; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t4_cnt7", 48'(AQueCnt), 48'd7);
    chk("t4_full_noreq", 48'(ACodeRdReq), 48'd0);
    ACmdLen = 2'd1; ACmdPop = 1'b1; cyc(); ACmdPop = 1'b0;
    #1 chk("t4_pop_cnt6", 48'(AQueCnt), 48'd6);
    chk("t4_pop_req", 48'(ACodeRdReq), 48'd1);
    chk("t4_pop_top", AQueTop, 48'h0C0C_0B0B_0A0A);
    chk("t4_addr", 48'(ACodeAddr), 48'h105);
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h1111_1010; ACmdLen = 2'd3; ACmdPop = 1'b1;
    cyc(); ACodeDataVld = 1'b0; ACmdPop = 1'b0;
    #1 chk("t4_net_cnt", 48'(AQueCnt), 48'd5);
    chk("t4_net_ip", 48'(AIpThis), 48'h207);
    chk("t4_net_top", AQueTop, 48'h0F0F_0E0E_0D0D);

    // Load while a read is outstanding: stale data is discarded
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    AIpLoad = 1'b1; AIpNew = 23'h000200; cyc(); AIpLoad = 1'b0;
    #1 chk("t5_pend_noreq", 48'(ACodeRdReq), 48'd0);
    chk("t5_cnt0", 48'(AQueCnt), 48'd0);
    ACodeDataVld = 1'b1; ACodeMiso = 32'hDEAD_BEEF; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t5_stale_cnt", 48'(AQueCnt), 48'd0);
    chk("t5_req", 48'(ACodeRdReq), 48'd1);
    chk("t5_addr", 48'(ACodeAddr), 48'h100);
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'h5678_1234; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t5_cnt2", 48'(AQueCnt), 48'd2);
    chk("t5_top", AQueTop, 48'h0000_5678_1234);
    ACodeDataVld = 1'b1; ACodeMiso = 32'hFFFF_FFFF; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t5_nopend_vld", 48'(AQueCnt), 48'd2);

    // Reset while a read is pending
    ACodeRdAck = 1'b1; cyc(); ACodeRdAck = 1'b0;
    AResetH = 1'b1; cyc();
    #1 chk("t6_req", 48'(ACodeRdReq), 48'd0);
    chk("t6_addr", 48'(ACodeAddr), 48'd0);
    chk("t6_top", AQueTop, 48'd0);
    chk("t6_cnt", 48'(AQueCnt), 48'd0);
    chk("t6_ip", 48'(AIpThis), 48'd0);
    chk("t6_lenvld", 48'(ACmdLenValid), 48'd0);
    AResetH = 1'b0;
    ACodeDataVld = 1'b1; ACodeMiso = 32'hAAAA_5555; cyc(); ACodeDataVld = 1'b0;
    #1 chk("t6_late_cnt", 48'(AQueCnt), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ms_cmd_que.md
Name: ms_cmd_que

Overview:
- Instruction prefetch queue feeding the command decoder.
- Fetches 32-bit code words from the code memory port and stores them as 16-bit halfwords in a circular buffer.
- Presents the next 48 bits of code at the current IP as AQueTop.
- Reports whether the decoded command length is fully buffered, then pops that many halfwords when the command retires. An IP load (jump, trap, reset vector) flushes the queue and restarts fetching.

Parameters:
- DEPTH_HW, 8: queue capacity in halfwords; power of 2, at least 6.
- CNT_W, 4: counter width; must equal log2(DEPTH_HW)+1.

Ports:
- AClkH  in  1  clock.
- AResetH  in  1  synchronous reset, active high.
- AIpLoad  in  1  flush queue and restart at AIpNew.
- AIpNew  in  23  new IP [23:1], halfword granular.
- ACodeRdReq  out  1  code read request.
- ACodeAddr  out  22  code word address [23:2].
- ACodeRdAck  in  1  request accepted this cycle.
- ACodeDataVld  in  1  read data valid.
- ACodeMiso  in  32  read data; [15:0] is the lower address.
- AQueTop  out  48  [15:0] is the halfword at AIpThis, [31:16] is IP+1, [47:32] is IP+2.
- AQueCnt  out  CNT_W  halfwords buffered.
- AIpThis  out  23  IP of the halfword at the queue head.
- ACmdLen  in  2  length of the decoded command in halfwords (0 means not decodable).
- ACmdLenValid  out  1  the decoded command is fully buffered.
- ACmdPop  in  1  command retired; pop ACmdLen halfwords.

Behaviour:
- Reset (synchronous, AResetH=1):
  - RdPtr, WrPtr, Cnt, AIpThis, FetchAddr, SkipLo, Pend, Discard are all cleared.
  - All outputs are 0.
  - Reset mid-transaction drops any outstanding read; Pend=0, so late data is treated as not pending and ignored.
- Storage: DEPTH_HW x 16 registers with RdPtr/WrPtr wrapping modulo DEPTH_HW.
- AQueTop: slot k (k = 0..2) is mem[RdPtr+k] if Cnt>k, otherwise 16'h0. It is combinational from registers.
- ACmdLenValid = (ACmdLen != 0) && (Cnt >= ACmdLen). Purely combinational.
- Fetch handshake:
  - ACodeRdReq = !Pend && (DEPTH_HW - Cnt >= 2) && !AIpLoad.
  - ACodeAddr = FetchAddr, held stable while the request is high.
  - On ACodeRdReq && ACodeRdAck: Pend<=1 and FetchAddr<=FetchAddr+1 (wraps at 22 bits).
  - At most one read is outstanding. Data may arrive no earlier than the cycle after Ack.
- Data write, on ACodeDataVld && Pend:
  - Pend<=0.
  - If Discard: drop the data and set Discard<=0.
  - Else if SkipLo: write ACodeMiso[31:16] only (+1 halfword) and set SkipLo<=0.
  - Else: write [15:0] then [31:16] (+2 halfwords).
  - ACodeDataVld with Pend=0 is ignored.
- Pop, on ACmdPop && ACmdLenValid:
  - RdPtr+=ACmdLen.
  - AIpThis+=ACmdLen (wraps at 23 bits).
  - ACmdPop without ACmdLenValid is ignored.
- Simultaneous write and pop in the same cycle: Cnt <= Cnt + written - popped. The free-space check in the request rule guarantees no overflow.
- AIpLoad has priority over pop, write and request in the same cycle:
  - Cnt<=0, RdPtr<=WrPtr.
  - AIpThis<=AIpNew.
  - FetchAddr<=AIpNew[23:2], SkipLo<=AIpNew[1].
  - Discard<=Pend.
  - Data arriving in the same cycle is dropped. In that case Pend<=0 and Discard<=0, because that data was the outstanding read.
  - A back-to-back AIpLoad keeps Discard set while a read is still pending.
- Empty queue: AQueTop=0 and ACmdLenValid=0 for any ACmdLen.
- Full queue (free < 2): no request is issued; a pop re-enables fetching in the next cycle.

Test Plan:
- Reset, then AIpLoad with AIpNew=23'h000100 (byte 0x200). Memory returns 32'hBBBBAAAA then 32'hDDDDCCCC with one-cycle latency -> ACodeAddr 0x80 then 0x81; AQueTop=48'hCCCC_BBBB_AAAA; Cnt=4.
- AIpLoad with AIpNew=23'h000101 (odd halfword), data 32'h2222_1111 -> only 16'h2222 enqueued; AQueTop[15:0]=16'h2222; Cnt=1; AIpThis=0x101.
- Cnt=2, ACmdLen=3 -> ACmdLenValid=0 and ACmdPop is ignored. After the next word arrives (Cnt=4), pop with ACmdLen=3 -> AIpThis+=3, Cnt=1.
- Fill until Cnt=7 (DEPTH_HW=8) -> ACodeRdReq=0. Pop 1 halfword -> ACodeRdReq=1 the next cycle. Write and pop in the same cycle -> Cnt updates by the net amount.
- Read acked, then AIpLoad to 0x200 before the data returns -> the stale word is discarded, Cnt stays 0, the next request goes to ACodeAddr=0x100, and its data appears at AQueTop.
- AResetH asserted while Pend=1 -> all outputs 0 the next cycle; a late ACodeDataVld does not change Cnt.
